hazard_stall_ctrl: RTL and testbench

- Stall/flush controller for the 5-stage pipeline; it complements the forwarding unit.
- Covers the hazards that forwarding cannot resolve: load-use RAW, taken branch/jump in E, and variable-latency data-memory wait states in M.
- Drives per-stage stall enables and flush (bubble) controls for the pipeline registers.
- Keeps saturating performance counters and a sticky memory-timeout flag.

---
 rtl/hazard_stall_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Stall/flush controller for the 5-stage pipeline. It handles the hazards that
// the forwarding unit cannot resolve:
//   - load-use RAW hazards (one bubble injected into E),
//   - taken branches/jumps resolved in E (wrong-path D and E are squashed),
//   - variable-latency data-memory accesses in M (whole front end frozen, a
//     bubble enters W), with a timeout that parks the pipeline in HALT.
// It also keeps saturating performance counters and a sticky timeout flag.
//
// Handshake: the memory access in M is a request/acknowledge pair. MemReqM is
// held high by the pipeline while an access sits in M; the access completes in
// the cycle MemAckM is high. MemAckM without MemReqM is meaningless in IDLE and
// is ignored.
//
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   Rs1D, Rs2D             source registers of the instruction in D
//   RdE, LoadE             destination register / load flag of instruction in E
//   PCSrcE                 taken branch/jump resolved in E
//   MemReqM, MemAckM       memory access active in M / completes this cycle
//   StallF..StallM         hold enables for PC, IF/ID, ID/EX, EX/MEM
//   FlushD, FlushE, FlushW bubble insertion for IF/ID, ID/EX, MEM/WB
//   MemTimeout             sticky: memory exceeded MAX_WAIT wait cycles
//   LoadStallCnt           cycles stalled for load-use (saturating)
//   FlushCnt               branch flush events (saturating)
//   MemWaitCnt             cycles stalled for memory (saturating, HALT excluded)
//   dbg_state              current FSM state (0=IDLE, 1=WAIT, 2=HALT)
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemAckM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] LoadStallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] MemWaitCnt,
    output logic [1:0]       dbg_state
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic memstall;
    logic lwstall;
    logic branch_act;
    logic load_act;
    logic memwait_act;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Hazard detection and priority resolution. The memory stall freezes the
    // whole front end, so a pending branch or load-use in E simply waits and is
    // re-evaluated in the first cycle after release (including the ack cycle).
    always_comb begin
        memstall    = ((state == IDLE) & MemReqM & ~MemAckM)
                    | ((state == WAIT) & ~MemAckM)
                    |  (state == HALT);
        lwstall     = LoadE & (RdE != 5'd0) & ((Rs1D == RdE) | (Rs2D == RdE));
        branch_act  = ~memstall & PCSrcE;
        // A taken branch discards the instruction in D, so its load-use hazard
        // does not need a bubble.
        load_act    = ~memstall & ~PCSrcE & lwstall;
        memwait_act = memstall & (state != HALT);
    end

    // Control outputs are gated by reset_n so the pipeline sees no spurious
    // stalls/flushes while reset is asserted.
    always_comb begin
        StallF = reset_n & (memstall | load_act);
        StallD = reset_n & (memstall | load_act);
        StallE = reset_n & memstall;
        StallM = reset_n & memstall;
        FlushD = reset_n & branch_act;
        FlushE = reset_n & (branch_act | load_act);
        FlushW = reset_n & memstall;
    end

    // Memory-wait FSM. wait_cnt holds the number of WAIT cycles spent so far,
    // counting the current one; timeout is declared when the MAX_WAIT-th WAIT
    // cycle also ends without an acknowledge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            MemTimeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemReqM & ~MemAckM) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                WAIT: begin
                    if (MemAckM) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                        state      <= HALT;
                        MemTimeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                HALT: begin
                    // Absorbing until reset; a late acknowledge is ignored.
                    state      <= HALT;
                    MemTimeout <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Performance counters, each counting the action actually applied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            LoadStallCnt <= '0;
            FlushCnt     <= '0;
            MemWaitCnt   <= '0;
        end else begin
            if (load_act)    LoadStallCnt <= sat_inc(LoadStallCnt);
            if (branch_act)  FlushCnt     <= sat_inc(FlushCnt);
            if (memwait_act) MemWaitCnt   <= sat_inc(MemWaitCnt);
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Directed bench for hazard_stall_ctrl with MAX_WAIT=4 and CNT_W=2. Inputs
// change 1 time unit after a rising edge; outputs are checked 1 unit later,
// well away from the next edge. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [4:0]       Rs1D, Rs2D, RdE;
    logic             LoadE, PCSrcE, MemReqM, MemAckM;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW, MemTimeout;
    logic [CNT_W-1:0] LoadStallCnt, FlushCnt, MemWaitCnt;
    logic [1:0]       dbg_state;

    hazard_stall_ctrl #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .Rs1D         (Rs1D),
        .Rs2D         (Rs2D),
        .RdE          (RdE),
        .LoadE        (LoadE),
        .PCSrcE       (PCSrcE),
        .MemReqM      (MemReqM),
        .MemAckM      (MemAckM),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .MemTimeout   (MemTimeout),
        .LoadStallCnt (LoadStallCnt),
        .FlushCnt     (FlushCnt),
        .MemWaitCnt   (MemWaitCnt),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed control vector: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    function automatic logic [6:0] ctl();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic ld, input logic br, input logic req, input logic ack);
        Rs1D    = rs1;
        Rs2D    = rs2;
        RdE     = rd;
        LoadE   = ld;
        PCSrcE  = br;
        MemReqM = req;
        MemAckM = ack;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected load-stall counter values while saturating at 2 bits.
    logic [CNT_W-1:0] sat_seq [6];

    // ---------------- directed sequence ----------------
    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        // Reset: even with a memory request pending, outputs stay low.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        chk("rst_ctl", ctl(), 7'b0000000);
        chk("rst_state", dbg_state, 2'd0);
        chk("rst_timeout", MemTimeout, 1'b0);
        chk("rst_cnt", {LoadStallCnt, FlushCnt, MemWaitCnt}, 6'd0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #8 reset_n = 1'b1;  // released at t=12, between edges
        tick();

        // Load-use on Rs1: one bubble.
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_rs1_ctl", ctl(), 7'b1100010);
        chk("lu_rs1_cnt_before", LoadStallCnt, 2'd0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_rs1_cnt_after", LoadStallCnt, 2'd1);
        chk("lu_release_ctl", ctl(), 7'b0000000);

        // x0 destination never stalls.
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_x0_ctl", ctl(), 7'b0000000);
        tick();
        chk("lu_x0_cnt", LoadStallCnt, 2'd1);

        // Load-use on Rs2.
        drive(5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_rs2_ctl", ctl(), 7'b1100010);
        tick();
        chk("lu_rs2_cnt", LoadStallCnt, 2'd2);

        // Matching register but not a load: no stall.
        drive(5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nonload_ctl", ctl(), 7'b0000000);
        tick();

        // Branch wins over simultaneous load-use.
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("br_lu_ctl", ctl(), 7'b0000110);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("br_lu_flushcnt", FlushCnt, 2'd1);
        chk("br_lu_lscnt", LoadStallCnt, 2'd2);

        // Memory wait of 3 cycles with a pending branch and load-use hazard.
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("mw_c1_ctl", ctl(), 7'b1111001);
        chk("mw_c1_state", dbg_state, 2'd0);
        tick();
        chk("mw_c2_state", dbg_state, 2'd1);
        chk("mw_c2_ctl", ctl(), 7'b1111001);
        tick();
        chk("mw_c3_state", dbg_state, 2'd1);
        chk("mw_c3_ctl", ctl(), 7'b1111001);
        chk("mw_c3_flushcnt", FlushCnt, 2'd1);
        tick();
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("mw_ack_ctl", ctl(), 7'b0000110);  // released; branch acted on now
        chk("mw_ack_waitcnt", MemWaitCnt, 2'd3);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mw_done_state", dbg_state, 2'd0);
        chk("mw_done_flushcnt", FlushCnt, 2'd2);
        chk("mw_done_lscnt", LoadStallCnt, 2'd2);
        chk("mw_done_waitcnt", MemWaitCnt, 2'd3);

        // Stray acknowledge without a request in IDLE.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("stray_ack_ctl", ctl(), 7'b0000000);
        tick();
        chk("stray_ack_state", dbg_state, 2'd0);

        // Asynchronous reset asserted mid-WAIT.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("rw_pre_state", dbg_state, 2'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rw_state", dbg_state, 2'd0);
        chk("rw_ctl", ctl(), 7'b0000000);
        chk("rw_cnt", {LoadStallCnt, FlushCnt, MemWaitCnt}, 6'd0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick();
        chk("rw_resume_state", dbg_state, 2'd0);

        // Timeout: request never acknowledged.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= MAX_WAIT; i++) begin
            tick();
            chk($sformatf("to_wait%0d_state", i), dbg_state, 2'd1);
            chk($sformatf("to_wait%0d_flag", i), MemTimeout, 1'b0);
        end
        chk("to_waitcnt", MemWaitCnt, 2'd3);
        tick();
        chk("to_halt_state", dbg_state, 2'd2);
        chk("to_halt_flag", MemTimeout, 1'b1);
        chk("to_halt_ctl", ctl(), 7'b1111001);

        // Late acknowledge and a branch are ignored in HALT.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("halt_ack_ctl", ctl(), 7'b1111001);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("halt_ack_state", dbg_state, 2'd2);
        chk("halt_ack_flag", MemTimeout, 1'b1);
        chk("halt_idle_ctl", ctl(), 7'b1111001);
        chk("halt_flushcnt", FlushCnt, 2'd0);

        // Asynchronous reset out of HALT.
        #2 reset_n = 1'b0;
        #1;
        chk("rh_state", dbg_state, 2'd0);
        chk("rh_flag", MemTimeout, 1'b0);
        chk("rh_ctl", ctl(), 7'b0000000);
        chk("rh_waitcnt", MemWaitCnt, 2'd0);
        reset_n = 1'b1;
        tick();

        // Saturation: hold load-use for 6 cycles.
        drive(5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("sat%0d_lscnt", i), LoadStallCnt, sat_seq[i]);
        end
        chk("sat_ctl", ctl(), 7'b1100010);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
